// File: rtl/exp_align_sched_if.sv
// Beat handshake bundle between the block-exponent source, the alignment
// scheduler and the mantissa aligners downstream.
interface exp_align_sched_if #(
    parameter int expWidth = 3
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [expWidth*4-1:0] in_exp;
    logic                  out_valid;
    logic                  out_ready;
    logic [expWidth*4-1:0] out_shift;
    logic [expWidth-1:0]   out_max;
    logic                  out_last;

    modport master (
        output in_valid, in_exp, out_ready,
        input  in_ready, out_valid, out_shift, out_max, out_last
    );

    modport slave (
        input  in_valid, in_exp, out_ready,
        output in_ready, out_valid, out_shift, out_max, out_last
    );
endinterface

// File: rtl/exp_align_sched.sv
// Block-floating-point alignment scheduler: buffers a block of four-lane
// exponent beats, finds the block maximum, then replays per-lane shift amounts.
module exp_align_sched #(
    parameter int expWidth = 3,
    parameter int MAX_LEN  = 8,
    parameter int LEN_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    exp_align_sched_if.slave bus
);

    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int BEAT_W = 4 * expWidth;

    typedef logic [expWidth-1:0] exp_t;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    function automatic exp_t max2(input exp_t a, input exp_t b);
        return (a > b) ? a : b;
    endfunction

    // 4-input max-exponent comparator tree
    function automatic exp_t max4(input logic [BEAT_W-1:0] beat);
        return max2(max2(beat[0 +: expWidth], beat[expWidth +: expWidth]),
                    max2(beat[2*expWidth +: expWidth], beat[3*expWidth +: expWidth]));
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_W'(1);
        if (l > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        return l;
    endfunction

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  rd;
    logic [LEN_W-1:0]  len;
    exp_t              max_reg;
    logic [BEAT_W-1:0] mem [MAX_LEN];
    logic [BEAT_W-1:0] rd_beat;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    exp_t              beat_max;
    logic              in_fire;
    logic              out_fire;
    logic              last_beat;

    assign bus.in_ready = (state != EMIT);
    assign busy         = (state != IDLE);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;
    assign last_beat    = (rd == len - LEN_W'(1));
    assign beat_max     = max4(bus.in_exp);
    assign wr_idx       = (state == IDLE) ? '0 : count[IDX_W-1:0];
    assign rd_idx       = rd[IDX_W-1:0];
    assign rd_beat      = mem[rd_idx];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_fire)
                      state_nxt = (clamp_len(cfg_len) == LEN_W'(1)) ? EMIT : SCAN;
            SCAN: if (in_fire && (count + LEN_W'(1) == len))
                      state_nxt = EMIT;
            EMIT: if (out_fire && last_beat)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            rd      <= '0;
            len     <= '0;
            max_reg <= '0;
        end else begin
            case (state)
                IDLE: if (in_fire) begin
                    count   <= LEN_W'(1);
                    rd      <= '0;
                    len     <= clamp_len(cfg_len);
                    max_reg <= beat_max;
                end
                SCAN: if (in_fire) begin
                    count   <= count + LEN_W'(1);
                    max_reg <= max2(max_reg, beat_max);
                end
                EMIT: if (out_fire) begin
                    rd <= last_beat ? '0 : rd + LEN_W'(1);
                    if (last_beat)
                        count <= '0;
                end
                default: ;
            endcase
        end
    end

    // Beat storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (in_fire)
            mem[wr_idx] <= bus.in_exp;
    end

    // Replay stage: everything below is decoded from registered state only
    always_comb begin
        bus.out_valid = (state == EMIT);
        bus.out_max   = '0;
        bus.out_last  = 1'b0;
        bus.out_shift = '0;
        if (state == EMIT) begin
            bus.out_max  = max_reg;
            bus.out_last = last_beat;
            for (int i = 0; i < 4; i++)
                bus.out_shift[i*expWidth +: expWidth] = max_reg - rd_beat[i*expWidth +: expWidth];
        end
    end

endmodule

// File: tb/tb_exp_align_sched.sv
// Self-checking bench for exp_align_sched: directed and randomized blocks
// compared against a block-level reference model.
module tb_exp_align_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cfg_len;
    logic       busy;

    exp_align_sched_if #(.expWidth(3)) bus_if ();

    exp_align_sched #(.expWidth(3), .MAX_LEN(8), .LEN_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_len (cfg_len),
        .busy    (busy),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0]  blk [8][4];
    logic [11:0] obs_shift [16];
    logic [2:0]  obs_max [16];
    logic        obs_last [16];
    logic        obs_rdy [16];
    int          collect_got;

    function automatic logic [11:0] pack(input int i);
        return {blk[i][3], blk[i][2], blk[i][1], blk[i][0]};
    endfunction

    function automatic logic [2:0] model_max(input int n);
        logic [2:0] m = 3'd0;
        for (int i = 0; i < n; i++)
            for (int l = 0; l < 4; l++)
                if (blk[i][l] > m) m = blk[i][l];
        return m;
    endfunction

    function automatic logic [11:0] model_shift(input int i, input logic [2:0] m);
        logic [11:0] r;
        for (int l = 0; l < 4; l++)
            r[l*3 +: 3] = m - blk[i][l];
        return r;
    endfunction

    function automatic int model_len(input logic [3:0] c);
        if (c == 4'd0) return 1;
        if (c > 4'd8) return 8;
        return int'(c);
    endfunction

    task automatic fill_random(input int n, input int hi);
        for (int i = 0; i < n; i++)
            for (int l = 0; l < 4; l++)
                blk[i][l] = 3'($urandom_range(0, hi));
    endtask

    // Presents n beats starting at a negedge; returns at the negedge after the last accept
    task automatic send(input int n, input logic [3:0] cfg_first, input logic [3:0] cfg_rest, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus_if.in_valid = 1'b0;
                @(negedge clk);
            end
            while (!bus_if.in_ready && g < 40) begin
                @(negedge clk);
                g++;
            end
            bus_if.in_valid = 1'b1;
            bus_if.in_exp   = pack(i);
            cfg_len         = (i == 0) ? cfg_first : cfg_rest;
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_exp   = 12'h000;
    endtask

    // Captures n output beats starting at index base; returns at the negedge after the last handshake
    task automatic collect(input int n, input int base, input bit rnd);
        int g = 0;
        collect_got = 0;
        while (collect_got < n && g < 300) begin
            bus_if.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus_if.out_valid && bus_if.out_ready) begin
                obs_shift[base + collect_got] = bus_if.out_shift;
                obs_max[base + collect_got]   = bus_if.out_max;
                obs_last[base + collect_got]  = bus_if.out_last;
                obs_rdy[base + collect_got]   = bus_if.in_ready;
                collect_got++;
            end
            @(negedge clk);
            g++;
        end
        bus_if.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus_if.in_ready); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus_if.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (bus_if.out_shift !== 12'h000) begin errors++; $display("FAIL reset_out_shift got %h want 000", bus_if.out_shift); end
        checks++; if (bus_if.out_max !== 3'd0) begin errors++; $display("FAIL reset_out_max got %0d want 0", bus_if.out_max); end
        checks++; if (bus_if.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus_if.out_last); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [2:0] m;
        blk[0][0] = 3'd3; blk[0][1] = 3'd1; blk[0][2] = 3'd5; blk[0][3] = 3'd2;
        m = model_max(1);
        send(1, 4'd1, 4'd1, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency out_valid got %b want 1", bus_if.out_valid); end
        collect(1, 0, 1'b0);
        checks++; if (collect_got != 1) begin errors++; $display("FAIL single_count got %0d want 1", collect_got); end
        checks++; if (obs_max[0] !== m) begin errors++; $display("FAIL single_max got %0d want %0d", obs_max[0], m); end
        checks++; if (obs_shift[0] !== model_shift(0, m)) begin errors++; $display("FAIL single_shift got %h want %h", obs_shift[0], model_shift(0, m)); end
        checks++; if (obs_last[0] !== 1'b1) begin errors++; $display("FAIL single_last got %b want 1", obs_last[0]); end
        checks++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_after in_ready/out_valid got %b%b want 10", bus_if.in_ready, bus_if.out_valid); end
    endtask

    task automatic test_three();
        logic [2:0] m;
        for (int l = 0; l < 4; l++) begin
            blk[0][l] = 3'd1;
            blk[1][l] = (l == 0) ? 3'd2 : 3'd0;
            blk[2][l] = (l == 2) ? 3'd7 : 3'd0;
        end
        m = model_max(3);
        send(3, 4'd3, 4'd3, 1'b0);
        collect(3, 0, 1'b0);
        checks++; if (collect_got != 3) begin errors++; $display("FAIL three_count got %0d want 3", collect_got); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_shift[i] !== model_shift(i, m)) begin errors++; $display("FAIL three_shift beat %0d got %h want %h", i, obs_shift[i], model_shift(i, m)); end
            checks++; if (obs_max[i] !== m) begin errors++; $display("FAIL three_max beat %0d got %0d want %0d", i, obs_max[i], m); end
            checks++; if (obs_last[i] !== (i == 2)) begin errors++; $display("FAIL three_last beat %0d got %b want %b", i, obs_last[i], (i == 2)); end
            checks++; if (obs_rdy[i] !== 1'b0) begin errors++; $display("FAIL three_in_ready beat %0d got %b want 0", i, obs_rdy[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  m;
        logic [11:0] snap_s;
        logic [2:0]  snap_m;
        logic        snap_l;
        fill_random(5, 7);
        m = model_max(5);
        send(5, 4'd5, 4'd5, 1'b0);
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_pre_valid beat %0d got %b want 1", k, bus_if.out_valid); end
            obs_shift[k] = bus_if.out_shift; obs_max[k] = bus_if.out_max; obs_last[k] = bus_if.out_last;
            @(negedge clk);
        end
        bus_if.out_ready = 1'b0;
        snap_s = bus_if.out_shift; snap_m = bus_if.out_max; snap_l = bus_if.out_last;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.out_valid, bus_if.out_shift, bus_if.out_max, bus_if.out_last, bus_if.in_ready} !== {1'b1, snap_s, snap_m, snap_l, 1'b0}) begin
                errors++;
                $display("FAIL bp_stall cycle %0d got %b_%h_%0d_%b_%b want 1_%h_%0d_%b_0", c, bus_if.out_valid, bus_if.out_shift,
                         bus_if.out_max, bus_if.out_last, bus_if.in_ready, snap_s, snap_m, snap_l);
            end
        end
        collect(3, 2, 1'b0);
        checks++; if (collect_got != 3) begin errors++; $display("FAIL bp_count got %0d want 3", collect_got); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_shift[i] !== model_shift(i, m) || obs_max[i] !== m || obs_last[i] !== (i == 4)) begin
                errors++; $display("FAIL bp_beat %0d got %h/%0d/%b want %h/%0d/%b", i, obs_shift[i], obs_max[i], obs_last[i], model_shift(i, m), m, (i == 4));
            end
        end
    endtask

    task automatic test_len_clamp();
        logic [2:0] m;
        logic [3:0] cfgs [3];
        logic [3:0] rest [3];
        int         n;
        cfgs[0] = 4'd0;  rest[0] = 4'd0;
        cfgs[1] = 4'd15; rest[1] = 4'd15;
        cfgs[2] = 4'd8;  rest[2] = 4'd2;
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 1 : 8;
            fill_random(n, 7);
            m = model_max(n);
            send(n, cfgs[t], rest[t], 1'b0);
            checks++; if (bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL clamp_done case %0d in_ready/out_valid got %b%b want 01", t, bus_if.in_ready, bus_if.out_valid); end
            collect(n, 0, 1'b0);
            checks++; if (collect_got != n) begin errors++; $display("FAIL clamp_count case %0d got %0d want %0d", t, collect_got, n); end
            for (int i = 0; i < n; i++) begin
                checks++; if (obs_shift[i] !== model_shift(i, m) || obs_max[i] !== m || obs_last[i] !== (i == n - 1)) begin
                    errors++; $display("FAIL clamp_beat case %0d beat %0d got %h/%0d/%b want %h/%0d/%b", t, i, obs_shift[i], obs_max[i], obs_last[i], model_shift(i, m), m, (i == n - 1));
                end
            end
            checks++; if (bus_if.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clamp_extra case %0d out_valid/busy got %b%b want 00", t, bus_if.out_valid, busy); end
        end
    endtask

    task automatic test_reset_mid_block();
        logic [2:0] m;
        fill_random(3, 7);
        send(2, 4'd3, 4'd3, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus_if.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus_if.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        blk[0][0] = 3'd4; blk[0][1] = 3'd4; blk[0][2] = 3'd4; blk[0][3] = 3'd0;
        m = model_max(1);
        send(1, 4'd1, 4'd1, 1'b0);
        collect(1, 0, 1'b0);
        checks++; if (collect_got != 1 || obs_max[0] !== m || obs_shift[0] !== model_shift(0, m) || obs_last[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_next got n=%0d %h/%0d/%b want n=1 %h/%0d/1", collect_got, obs_shift[0], obs_max[0], obs_last[0], model_shift(0, m), m);
        end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got out_valid %b want 0", bus_if.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] m;
        fill_random(4, 7);
        blk[3][1] = 3'd7;
        send(4, 4'd4, 4'd4, 1'b0);
        collect(4, 0, 1'b0);
        checks++; if (collect_got != 4 || obs_last[3] !== 1'b1) begin errors++; $display("FAIL b2b_first got n=%0d last=%b want n=4 last=1", collect_got, obs_last[3]); end
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_last got %b want 1", bus_if.in_ready); end
        fill_random(3, 3);
        m = model_max(3);
        send(3, 4'd3, 4'd3, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_latency got %b want 1", bus_if.out_valid); end
        collect(3, 0, 1'b0);
        checks++; if (collect_got != 3) begin errors++; $display("FAIL b2b_second_count got %0d want 3", collect_got); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_shift[i] !== model_shift(i, m) || obs_max[i] !== m) begin
                errors++; $display("FAIL b2b_second_beat %0d got %h/%0d want %h/%0d", i, obs_shift[i], obs_max[i], model_shift(i, m), m);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] m;
        logic [3:0] c;
        int         n;
        for (int b = 0; b < 20; b++) begin
            c = 4'($urandom_range(0, 15));
            n = model_len(c);
            fill_random(n, 7);
            m = model_max(n);
            send(n, c, 4'($urandom_range(0, 15)), 1'b1);
            collect(n, 0, 1'b1);
            checks++; if (collect_got != n) begin errors++; $display("FAIL rand_count block %0d got %0d want %0d", b, collect_got, n); end
            for (int i = 0; i < n; i++) begin
                checks++; if (obs_shift[i] !== model_shift(i, m) || obs_max[i] !== m || obs_last[i] !== (i == n - 1) || obs_rdy[i] !== 1'b0) begin
                    errors++; $display("FAIL rand_beat block %0d beat %0d got %h/%0d/%b/%b want %h/%0d/%b/0", b, i, obs_shift[i], obs_max[i],
                                       obs_last[i], obs_rdy[i], model_shift(i, m), m, (i == n - 1));
                end
            end
            checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rand_extra block %0d out_valid got %b want 0", b, bus_if.out_valid); end
        end
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_exp    = 12'h000;
        bus_if.out_ready = 1'b1;
        cfg_len          = 4'd1;
        test_reset();
        test_single();
        test_three();
        test_backpressure();
        test_len_clamp();
        test_reset_mid_block();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_align_sched.md
Name: exp_align_sched

Overview:
- Block-floating-point alignment scheduler for the gemm datapath.
- Accepts a block of beats, each carrying four lane exponents, and buffers every beat.
- Tracks the running block-maximum exponent using the team's 4-input max-exponent comparator plus one 2-input comparison against the running max.
- Once the block is complete, replays each beat with per-lane right-shift amounts (block max minus lane exponent) for the mantissa aligners.

Parameters:
- expWidth, 3: width of each lane exponent, unsigned.
- MAX_LEN, 8: buffer depth in beats; maximum block length.
- LEN_W, 4: width of cfg_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  LEN_W  beats per block; sampled only when the first beat of a block is accepted.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_exp  in  expWidth*4  lane i exponent at bits [expWidth*i +: expWidth].
- out_valid  out  1  aligned beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_shift  out  expWidth*4  lane i shift amount, same packing as in_exp.
- out_max  out  expWidth  block maximum exponent.
- out_last  out  1  marks the final beat of a block.
- busy  out  1  high in SCAN or EMIT.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; beat count, read pointer, latched length and max register all 0.
  - out_valid=0, out_shift=0, out_max=0, out_last=0, busy=0.
  - in_ready=1 (in_ready is decoded from state).
- Handshakes: a transfer occurs when valid&&ready on a rising edge. Standard valid/ready rules apply.
- Length handling: latched length L = max(1, min(cfg_len, MAX_LEN)). Changes to cfg_len after the first beat of a block are ignored.
- IDLE:
  - in_ready=1.
  - On accept: write buf[0], max_reg=max4(in_exp), count=1, latch L.
  - Next state: EMIT if L==1, else SCAN.
- SCAN:
  - in_ready=1.
  - On accept: write buf[count], max_reg=max(max_reg, max4(in_exp)) (unsigned), count+1.
  - When the accepted beat brings count to L, go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1, rd starts at 0.
  - out_shift lane i = max_reg - buf[rd] lane i. This is unsigned expWidth-bit and never underflows.
  - out_max=max_reg, held constant for the whole block.
  - out_last=(rd==L-1).
  - On an out handshake: rd+1. On the handshake of the last beat, go to IDLE and clear out_valid.
- Latency: out_valid rises on the clock edge that accepts the last input beat, i.e. visible in the following cycle. One beat per cycle when out_ready is held at 1. A new block may be accepted in the cycle after the last output handshake.
- Output timing: outputs depend only on registered state, buffer and max_reg. There is no combinational path from in_* to out_*. Outputs stay stable while out_valid&&!out_ready.
- Tie and degenerate cases: ties in the max need no special handling. An all-zero block gives all shifts 0 and out_max=0.
- Reset mid-block: the block is discarded and the beats never appear at the output.

Test Plan:
- Single beat, L=1: in_exp lanes {3,1,5,2} -> next cycle out_valid=1, out_max=5, out_shift {2,4,0,3}, out_last=1; then in_ready=1.
- Three beats, L=3: {1,1,1,1}, {2,0,0,0}, {0,0,7,0} -> out_max=7; out_shift {6,6,6,6}, {5,7,7,7}, {7,7,0,7}; out_last only on the third beat.
- Backpressure: out_ready=0 for 4 cycles mid-EMIT -> out_* stable, in_ready=0 throughout, no beat dropped or duplicated, correct order after release.
- Length clamp: cfg_len=0 -> one beat per block; cfg_len=15 -> 8 beats per block. Changing cfg_len to 2 after the first beat of an 8-beat block still yields 8 outputs.
- Reset mid-block: assert rst after 2 of 3 beats -> out_valid=0 and busy=0 immediately, in_ready=1. A following L=1 block {4,4,4,0} gives out_max=4, out_shift {0,0,0,4}.
- Back-to-back blocks: with out_ready=1 throughout, the first beat of the next block is accepted the cycle after the last out handshake and has an independent out_max.
